mac2fifo_pack: RTL and testbench

MAC2FIFO_PACK -- requirements
Module: mac2fifo_pack

---
 rtl/mac2fifo_pack_if.sv | 35 +++
 rtl/mac2fifo_pack.sv | 171 +++++++++++++++++
 tb/tb_mac2fifo_pack.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac2fifo_pack_if.sv
// mac2fifo_pack_if: bundles the controller handshake, the MAC RX buffer read
// port and the FIFO write port used by mac2fifo_pack.
//   fs/fd/err   : start level in, done / length-error levels out
//   udp_rxd     : buffer read data (valid one clk after udp_rx_addr)
//   udp_rx_addr : buffer read address
//   udp_rx_len  : UDP length including header
//   fifo_txd    : packed payload word, fifo_txen: one-cycle write strobe
//   fifo_full   : FIFO cannot accept a write this cycle
//   dev_rx_len  : latched payload length
// master = the packer, slave = controller/buffer/FIFO side.
interface mac2fifo_pack_if #(
  parameter int ADDR_W    = 11,
  parameter int OUT_BYTES = 4
);
  logic                   fs;
  logic                   fd;
  logic                   err;
  logic [7:0]             udp_rxd;
  logic [ADDR_W-1:0]      udp_rx_addr;
  logic [15:0]            udp_rx_len;
  logic [8*OUT_BYTES-1:0] fifo_txd;
  logic                   fifo_txen;
  logic                   fifo_full;
  logic [15:0]            dev_rx_len;

  modport master (
    input  fs, udp_rxd, udp_rx_len, fifo_full,
    output fd, err, udp_rx_addr, fifo_txd, fifo_txen, dev_rx_len
  );

  modport slave (
    output fs, udp_rxd, udp_rx_len, fifo_full,
    input  fd, err, udp_rx_addr, fifo_txd, fifo_txen, dev_rx_len
  );
endinterface

// File: rtl/mac2fifo_pack.sv
// mac2fifo_pack: reads a UDP payload out of the MAC RX buffer one byte per
// clk, packs bytes first-byte-in-MSB into OUT_BYTES-wide words and writes
// them to a FIFO, honouring fifo_full backpressure.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : mac2fifo_pack_if.master (see interface for signal list); its
//         ADDR_W/OUT_BYTES must match this module's parameters.
module mac2fifo_pack #(
  parameter int ADDR_W    = 11,
  parameter int OUT_BYTES = 4,
  parameter int HDR_LEN   = 8,
  parameter int MAX_LEN   = 1472
) (
  input  logic            clk,
  input  logic            rst,
  mac2fifo_pack_if.master bus
);

  localparam int W  = 8 * OUT_BYTES;
  localparam int CW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, READ, DONE, ERR} state_t;
  state_t state, state_nxt;

  logic [15:0]   len_q;
  logic [15:0]   rd_idx;     // next buffer address to issue
  logic          issue_done; // all L addresses issued
  logic          rd_vld;     // udp_rxd carries a requested byte this cycle
  logic          rd_last;    // ... and it is byte L-1
  logic [W-1:0]  acc;        // partial word, unfilled bytes kept at zero
  logic [CW-1:0] cnt;        // bytes already in acc
  logic [W-1:0]  out_word;   // complete word waiting for the FIFO
  logic          out_vld;
  logic          out_last;
  logic [7:0]    skid;       // completing byte that arrived while out_word blocked
  logic          skid_vld;
  logic          skid_last;

  logic [15:0] len_calc;
  logic        len_bad;
  logic        in_read, stall, issue, accept, word_done;

  assign len_calc = bus.udp_rx_len - 16'(HDR_LEN);
  assign len_bad  = (bus.udp_rx_len <= 16'(HDR_LEN)) || (len_calc > 16'(MAX_LEN));

  assign in_read   = (state == READ);
  // Address issue stops only once a full word is stuck behind fifo_full;
  // the single byte already in flight then lands in acc or the skid.
  assign stall     = out_vld && bus.fifo_full;
  assign issue     = in_read && bus.fs && !issue_done && !stall;
  // fs gating makes an abort take effect in the same cycle fs drops.
  assign accept    = in_read && bus.fs && out_vld && !bus.fifo_full;
  assign word_done = (cnt == CW'(OUT_BYTES - 1)) || rd_last;

  function automatic logic [W-1:0] put_byte(input logic [W-1:0] w,
                                            input logic [CW-1:0] c,
                                            input logic [7:0] b);
    logic [W-1:0] r;
    r = w;
    r[W - 8 - 8*int'(c) +: 8] = b;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.fs) state_nxt = CHECK;
      CHECK: begin
        if (!bus.fs)     state_nxt = IDLE;
        else if (len_bad) state_nxt = ERR;
        else             state_nxt = READ;
      end
      READ: begin
        if (!bus.fs)                 state_nxt = IDLE;
        else if (accept && out_last) state_nxt = DONE;
      end
      DONE:    if (!bus.fs) state_nxt = IDLE;
      ERR:     if (!bus.fs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 len_q <= '0;
    else if (state == CHECK) len_q <= len_calc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx     <= '0;
      issue_done <= 1'b0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      out_word   <= '0;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      skid       <= '0;
      skid_vld   <= 1'b0;
      skid_last  <= 1'b0;
    end else if (!in_read) begin
      // Everything outside READ starts the next transfer from a clean slate
      // and discards whatever an abort left behind.
      rd_idx     <= '0;
      issue_done <= 1'b0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      out_word   <= '0;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      skid       <= '0;
      skid_vld   <= 1'b0;
      skid_last  <= 1'b0;
    end else begin
      if (issue) begin
        // Address holds at L-1 once the last byte has been requested.
        if (rd_idx == len_q - 16'd1) issue_done <= 1'b1;
        else                         rd_idx     <= rd_idx + 16'd1;
      end
      rd_vld  <= issue;
      rd_last <= issue && (rd_idx == len_q - 16'd1);

      if (accept) out_vld <= 1'b0;

      // A skid byte only exists while address issue is frozen, so it can
      // never coincide with a fresh arrival.
      if (skid_vld) begin
        if (accept) begin
          out_word <= put_byte(acc, cnt, skid);
          out_last <= skid_last;
          out_vld  <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
          skid_vld <= 1'b0;
        end
      end else if (rd_vld) begin
        if (!word_done) begin
          acc <= put_byte(acc, cnt, bus.udp_rxd);
          cnt <= cnt + CW'(1);
        end else if (!out_vld || accept) begin
          out_word <= put_byte(acc, cnt, bus.udp_rxd);
          out_last <= rd_last;
          out_vld  <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          skid      <= bus.udp_rxd;
          skid_vld  <= 1'b1;
          skid_last <= rd_last;
        end
      end
    end
  end

  assign bus.udp_rx_addr = in_read ? rd_idx[ADDR_W-1:0] : '0;
  assign bus.fifo_txen   = accept;
  assign bus.fifo_txd    = out_word;
  assign bus.fd          = (state == DONE);
  assign bus.err         = (state == ERR);
  assign bus.dev_rx_len  = len_q;

endmodule

// File: tb/tb_mac2fifo_pack.sv
module tb_mac2fifo_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac2fifo_pack_if #(.ADDR_W(11), .OUT_BYTES(4)) bus ();

  mac2fifo_pack #(.ADDR_W(11), .OUT_BYTES(4), .HDR_LEN(8), .MAX_LEN(1472)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem [0:2047];
  logic [31:0] exp_q [$];
  int          wr_cyc [$];
  int checks = 0, failures = 0, n_wr = 0, cyc = 0, base = 0, t0 = 0;

  // Synchronous-read buffer model: data follows the address by one clk.
  always @(posedge clk) bus.udp_rxd <= mem[bus.udp_rx_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write pops the next expected word.
  always @(negedge clk) begin
    logic [31:0] w;
    chk("fd_err_excl", {31'd0, bus.fd & bus.err}, 32'd0);
    if (bus.fifo_txen) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      w = 32'hxxxx_xxxx;
      if (exp_q.size() > 0) w = exp_q.pop_front();
      chk("wdata", bus.fifo_txd, w);
    end
  end

  task automatic push_exp(input int len);
    logic [31:0] w;
    for (int i = 0; i < len; i += 4) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if (i + b < len) w[31 - 8*b -: 8] = mem[i + b];
      exp_q.push_back(w);
    end
  endtask

  task automatic start(input int rxlen, input bit push);
    @(posedge clk); #1;
    bus.udp_rx_len = 16'(rxlen);
    if (push) push_exp(rxlen - 8);
    wr_cyc.delete();
    base = n_wr;
    t0 = cyc;
    bus.fs = 1'b1;
  endtask

  task automatic wait_fd(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      ok = bus.fd;
    end
  endtask

  task automatic stop();
    @(posedge clk); #1;
    bus.fs = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int maxc);
    int k = 0;
    for (int i = 0; i < maxc && k < n; i++) begin
      @(negedge clk);
      if (bus.fifo_txen) k++;
    end
    chk("wait_writes", k, n);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int stall_wr;
    logic [10:0] a [10];
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i + 1);
    bus.fs = 1'b0;
    bus.fifo_full = 1'b0;
    bus.udp_rx_len = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fd", bus.fd, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_txen", bus.fifo_txen, 0);
    chk("rst_addr", bus.udp_rx_addr, 0);
    chk("rst_txd", bus.fifo_txd, 0);
    chk("rst_devlen", bus.dev_rx_len, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", bus.udp_rx_addr, 0);

    // 8-byte payload, consecutive-byte schedule
    start(16, 1);
    wait_fd(40, ok);
    chk("A_done", ok, 1);
    chk("A_nwr", n_wr - base, 2);
    chk("A_first_wr", wr_cyc[0] - t0, 7);
    chk("A_gap", wr_cyc[1] - wr_cyc[0], 4);
    chk("A_devlen", bus.dev_rx_len, 8);
    chk("A_err", bus.err, 0);
    chk("A_q_empty", exp_q.size(), 0);
    chk("A_done_addr", bus.udp_rx_addr, 0);
    stop();
    chk("A_fd_clear", bus.fd, 0);

    // 5-byte payload, zero padded tail
    start(13, 1);
    wait_fd(40, ok);
    chk("B_done", ok, 1);
    chk("B_nwr", n_wr - base, 2);
    chk("B_q_empty", exp_q.size(), 0);
    chk("B_devlen", bus.dev_rx_len, 5);
    stop();

    // Length errors: at header length and one past MAX_LEN
    start(8, 0);
    repeat (6) @(negedge clk);
    chk("C8_err", bus.err, 1);
    chk("C8_fd", bus.fd, 0);
    chk("C8_addr", bus.udp_rx_addr, 0);
    chk("C8_nwr", n_wr - base, 0);
    stop();
    chk("C8_err_clear", bus.err, 0);

    start(1481, 0);
    repeat (6) @(negedge clk);
    chk("C1481_err", bus.err, 1);
    chk("C1481_fd", bus.fd, 0);
    chk("C1481_nwr", n_wr - base, 0);
    chk("C1481_devlen", bus.dev_rx_len, 1473);
    stop();
    chk("C1481_err_clear", bus.err, 0);

    // Largest legal payload
    start(1480, 1);
    wait_fd(1600, ok);
    chk("M_done", ok, 1);
    chk("M_nwr", n_wr - base, 368);
    chk("M_q_empty", exp_q.size(), 0);
    stop();

    // 10-cycle stall after the 2nd write
    start(40, 1);
    wait_writes(2, 100);
    @(posedge clk); #1 bus.fifo_full = 1'b1;
    stall_wr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a[i] = bus.udp_rx_addr;
      if (bus.fifo_txen) stall_wr++;
    end
    @(posedge clk); #1 bus.fifo_full = 1'b0;
    chk("D_stall_nowr", stall_wr, 0);
    chk("D_addr_frozen", a[9], a[4]);
    wait_fd(100, ok);
    chk("D_done", ok, 1);
    chk("D_nwr", n_wr - base, 8);
    chk("D_q_empty", exp_q.size(), 0);
    stop();

    // Random backpressure, odd-length payload
    start(100, 1);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1 bus.fifo_full = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = bus.fd;
    end
    bus.fifo_full = 1'b0;
    chk("E_done", ok, 1);
    chk("E_nwr", n_wr - base, 23);
    chk("E_q_empty", exp_q.size(), 0);
    stop();

    // Abort after 3 writes
    start(40, 1);
    wait_writes(3, 100);
    @(posedge clk); #1 bus.fs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("F_addr", bus.udp_rx_addr, 0);
    chk("F_fd", bus.fd, 0);
    repeat (6) @(negedge clk);
    chk("F_nwr", n_wr - base, 3);
    chk("F_fd_late", bus.fd, 0);
    chk("F_err", bus.err, 0);
    exp_q.delete();

    // Reset mid-READ, then a clean transfer
    start(40, 1);
    repeat (8) @(negedge clk);
    chk("G_busy_addr_nz", 32'(bus.udp_rx_addr != 0), 1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("G_txen", bus.fifo_txen, 0);
    chk("G_addr", bus.udp_rx_addr, 0);
    chk("G_txd", bus.fifo_txd, 0);
    chk("G_devlen", bus.dev_rx_len, 0);
    chk("G_fd", bus.fd, 0);
    chk("G_err", bus.err, 0);
    exp_q.delete();
    bus.fs = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    start(16, 1);
    wait_fd(40, ok);
    chk("G_done", ok, 1);
    chk("G_nwr", n_wr - base, 2);
    chk("G_q_empty", exp_q.size(), 0);
    stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
